// File: rtl/qcw_pkg.sv
// ---------------------------------------------------------------------------
// qcw_pkg
// Shared types and elaboration-time helpers for the QCW ramp sequencer.
//   drv_mux_e   : drive source select (off / internal oscillator / feedback)
//   qcw_state_e : sequencer FSM states
//   ms_to_ticks, us_to_ticks : time to clock-tick conversion
//   step_ticks  : ticks per duty increment during the ramp (never below 1)
//   max3        : largest of three values, used to size the phase counter
// ---------------------------------------------------------------------------
package qcw_pkg;

  typedef enum logic [1:0] {
    MUX_OFF = 2'd0,
    MUX_INT = 2'd1,
    MUX_FB  = 2'd2
  } drv_mux_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PAUSE = 3'd1,
    ST_FLAT  = 3'd2,
    ST_RAMP  = 3'd3,
    ST_ABORT = 3'd4
  } qcw_state_e;

  // Integer Hz is divided first so the product stays within 32 bits.
  function automatic int ms_to_ticks(input int clk_hz, input int ms);
    return (clk_hz / 32'sd1000) * ms;
  endfunction

  function automatic int us_to_ticks(input int clk_hz, input int us);
    return (clk_hz / 32'sd1000000) * us;
  endfunction

  // A ramp shorter than its duty span would give zero; clamp to one tick.
  function automatic int step_ticks(input int ramp_ticks, input int flat_duty,
                                    input int max_duty);
    int span;
    int q;
    span = max_duty - flat_duty;
    q    = (span > 32'sd0) ? (ramp_ticks / span) : ramp_ticks;
    return (q < 32'sd1) ? 32'sd1 : q;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/qcw_ramp_seq_zc_watchdog.sv
// ---------------------------------------------------------------------------
// zc_watchdog
// Counts clock ticks since the last zero-cross while running. On reaching
// LIMIT it raises a one-cycle timeout pulse and latches "expired" until the
// next clear; the count then holds at LIMIT. A clear in the same cycle as the
// threshold wins, so no pulse is produced.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : zero-cross seen or burst (re)start; clears count and flag
//   i_run       : count this cycle
//   o_expired   : expired flag as it will be after the coming edge
//                 (lets the parent register a mux change in the same edge
//                 as the timeout pulse)
//   o_timeout   : registered one-cycle timeout pulse
// ---------------------------------------------------------------------------
module zc_watchdog #(
  parameter  int LIMIT = 2000,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired,
  output logic o_timeout
);

  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_expired;
  logic          r_timeout;
  logic          w_hit;

  // Threshold detection and look-ahead of the expired flag.
  always_comb begin
    w_hit = i_run && !i_clear && !r_expired && (r_cnt == CNT_LAST);
    if (i_clear) begin
      o_expired = 1'b0;
    end else if (w_hit) begin
      o_expired = 1'b1;
    end else begin
      o_expired = r_expired;
    end
  end

  // Tick counter, saturating at LIMIT, with expired flag and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
      r_timeout <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= '0;
      r_expired <= 1'b0;
      r_timeout <= 1'b0;
    end else if (i_run) begin
      r_timeout <= w_hit;
      r_expired <= o_expired;
      if (r_cnt != CNT_SAT) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/qcw_ramp_seq.sv
// ---------------------------------------------------------------------------
// qcw_ramp_seq
// Burst sequencer for a QCW drive: PAUSE (drive off) -> FLAT (soft-start at a
// fixed duty) -> RAMP (duty climbs one code per STEP_TICKS) -> IDLE with a
// done pulse. Bursts repeat while en is high; a burst once started runs to
// completion unless fault aborts it. A zero-cross watchdog falls back to the
// internal oscillator when feedback zero-crosses stop arriving.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : level, permits burst generation
//   fault        : level, immediate abort (highest priority)
//   zc           : one-cycle zero-cross pulse
//   ampl_ok      : feedback amplitude adequate
//   drv_mux      : drive source (0 off, 1 internal, 2 feedback)
//   duty         : duty code for the driver
//   drv_en       : gate drive enable
//   busy         : burst in progress (including abort)
//   done         : one-cycle pulse at normal end of burst
//   zc_timeout   : one-cycle pulse when the zero-cross watchdog expires
// ---------------------------------------------------------------------------
module qcw_ramp_seq
  import qcw_pkg::*;
#(
  parameter  int REF_CLK_HZ       = 100000000,
  parameter  int RAMP_PAUSE_MS    = 1,
  parameter  int FLAT_LENGTH_US   = 2000,
  parameter  int RAMP_LENGTH_US   = 10000,
  parameter  int DUTY_SCALE       = 100,
  parameter  int FLAT_DUTY        = 10,
  parameter  int MAX_DUTY         = 100,
  parameter  int ZC_TIMEOUT_TICKS = 2000,
  localparam int DUTY_BITS        = $clog2(DUTY_SCALE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fault,
  input  logic                 zc,
  input  logic                 ampl_ok,
  output logic [1:0]           drv_mux,
  output logic [DUTY_BITS-1:0] duty,
  output logic                 drv_en,
  output logic                 busy,
  output logic                 done,
  output logic                 zc_timeout
);

  localparam int PAUSE_TICKS = ms_to_ticks(REF_CLK_HZ, RAMP_PAUSE_MS);
  localparam int FLAT_TICKS  = us_to_ticks(REF_CLK_HZ, FLAT_LENGTH_US);
  localparam int RAMP_TICKS  = us_to_ticks(REF_CLK_HZ, RAMP_LENGTH_US);
  localparam int STEP_TICKS  = step_ticks(RAMP_TICKS, FLAT_DUTY, MAX_DUTY);
  localparam int CNT_MAX     = max3(PAUSE_TICKS, FLAT_TICKS, RAMP_TICKS);
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int STEP_W      = $clog2(STEP_TICKS + 1);

  // Phase counters run 0..N-1, so the last cycle of a phase is N-1.
  localparam logic [CNT_W-1:0]     PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [CNT_W-1:0]     FLAT_LAST  = CNT_W'(FLAT_TICKS - 1);
  localparam logic [CNT_W-1:0]     RAMP_LAST  = CNT_W'(RAMP_TICKS - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);
  localparam logic [STEP_W-1:0]    STEP_LAST  = STEP_W'(STEP_TICKS - 1);
  localparam logic [STEP_W-1:0]    STEP_ONE   = STEP_W'(1);
  localparam logic [DUTY_BITS-1:0] FLAT_CODE  = DUTY_BITS'(FLAT_DUTY);
  localparam logic [DUTY_BITS-1:0] MAX_CODE   = DUTY_BITS'(MAX_DUTY);
  localparam logic [DUTY_BITS-1:0] DUTY_ONE   = DUTY_BITS'(1);

  qcw_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [STEP_W-1:0]      r_step_cnt;
  logic [DUTY_BITS-1:0]   r_duty;
  drv_mux_e               r_drv_mux;
  logic                   r_drv_en;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_enter_flat;
  logic                   w_wd_clear;
  logic                   w_wd_run;
  logic                   w_wd_expired;
  logic                   w_wd_timeout;
  drv_mux_e               w_mux_sel;

  // Watchdog control and drive-source selection for FLAT/RAMP.
  always_comb begin
    w_enter_flat = (r_state == ST_PAUSE) && (r_cnt == PAUSE_LAST) && !fault;
    w_wd_clear   = zc || w_enter_flat;
    // An aborting edge must not also report a watchdog timeout.
    w_wd_run     = ((r_state == ST_FLAT) || (r_state == ST_RAMP)) && !fault;
    w_mux_sel    = (ampl_ok && !w_wd_expired) ? MUX_FB : MUX_INT;
  end

  zc_watchdog #(
    .LIMIT (ZC_TIMEOUT_TICKS)
  ) u_zc_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_run     (w_wd_run),
    .o_expired (w_wd_expired),
    .o_timeout (w_wd_timeout)
  );

  // Burst FSM with all drive outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_step_cnt <= '0;
      r_duty     <= '0;
      r_drv_mux  <= MUX_OFF;
      r_drv_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (fault) begin
        // Abort beats every other transition, including end of RAMP.
        r_state    <= ST_ABORT;
        r_cnt      <= '0;
        r_step_cnt <= '0;
        r_duty     <= '0;
        r_drv_mux  <= MUX_OFF;
        r_drv_en   <= 1'b0;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_drv_en  <= 1'b0;
            r_duty    <= '0;
            r_drv_mux <= MUX_OFF;
            r_cnt     <= '0;
            if (en) begin
              r_state <= ST_PAUSE;
              r_busy  <= 1'b1;
            end else begin
              r_busy  <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (r_cnt == PAUSE_LAST) begin
              r_state   <= ST_FLAT;
              r_cnt     <= '0;
              r_drv_en  <= 1'b1;
              r_duty    <= FLAT_CODE;
              r_drv_mux <= w_mux_sel;
            end else begin
              r_cnt     <= r_cnt + CNT_ONE;
            end
          end
          ST_FLAT: begin
            r_drv_mux <= w_mux_sel;
            if (r_cnt == FLAT_LAST) begin
              r_state    <= ST_RAMP;
              r_cnt      <= '0;
              r_step_cnt <= '0;
            end else begin
              r_cnt      <= r_cnt + CNT_ONE;
            end
          end
          ST_RAMP: begin
            if (r_cnt == RAMP_LAST) begin
              r_state    <= ST_IDLE;
              r_cnt      <= '0;
              r_step_cnt <= '0;
              r_drv_en   <= 1'b0;
              r_duty     <= '0;
              r_drv_mux  <= MUX_OFF;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_cnt     <= r_cnt + CNT_ONE;
              r_drv_mux <= w_mux_sel;
              if (r_step_cnt == STEP_LAST) begin
                r_step_cnt <= '0;
                // Saturate rather than wrap past the top code.
                if (r_duty < MAX_CODE) begin
                  r_duty <= r_duty + DUTY_ONE;
                end
              end else begin
                r_step_cnt <= r_step_cnt + STEP_ONE;
              end
            end
          end
          ST_ABORT: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_step_cnt <= '0;
            r_duty     <= '0;
            r_drv_mux  <= MUX_OFF;
            r_drv_en   <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign drv_mux    = r_drv_mux;
  assign duty       = r_duty;
  assign drv_en     = r_drv_en;
  assign busy       = r_busy;
  assign done       = r_done;
  assign zc_timeout = w_wd_timeout;

endmodule

// File: tb/tb_qcw_ramp_seq.sv
// ---------------------------------------------------------------------------
// tb_qcw_ramp_seq
// Self-checking bench for qcw_ramp_seq at REF_CLK_HZ=1 MHz: 1000-tick pause,
// 20-tick flat, 90-tick ramp at one duty code per tick, watchdog limit 8.
// ---------------------------------------------------------------------------
module tb_qcw_ramp_seq;

  localparam int PAUSE_T = 1000;
  localparam int FLAT_T  = 20;
  localparam int RAMP_T  = 90;
  localparam int FLAT_D  = 10;
  localparam int MAX_D   = 100;
  localparam int ZC_LIM  = 8;

  localparam logic [1:0] M_OFF = 2'd0;
  localparam logic [1:0] M_INT = 2'd1;
  localparam logic [1:0] M_FB  = 2'd2;

  // Watchdog scenario, indices relative to the FLAT entry edge.
  localparam int WD_LAST_ZC = 40;
  localparam int WD_TMO     = WD_LAST_ZC + ZC_LIM;
  localparam int WD_NEXT_ZC = 55;
  localparam int WD_RACE_ZC = WD_NEXT_ZC + ZC_LIM;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fault;
  logic       zc;
  logic       ampl_ok;
  logic [1:0] drv_mux;
  logic [6:0] duty;
  logic       drv_en;
  logic       busy;
  logic       done;
  logic       zc_timeout;

  qcw_ramp_seq #(
    .REF_CLK_HZ       (1000000),
    .RAMP_PAUSE_MS    (1),
    .FLAT_LENGTH_US   (20),
    .RAMP_LENGTH_US   (90),
    .DUTY_SCALE       (100),
    .FLAT_DUTY        (10),
    .MAX_DUTY         (100),
    .ZC_TIMEOUT_TICKS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fault      (fault),
    .zc         (zc),
    .ampl_ok    (ampl_ok),
    .drv_mux    (drv_mux),
    .duty       (duty),
    .drv_en     (drv_en),
    .busy       (busy),
    .done       (done),
    .zc_timeout (zc_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       drv_en;
    logic [6:0] duty;
    logic [1:0] mux;
    logic       busy;
    logic       done;
    logic       tmo;
  } exp_t;

  typedef struct {
    int         len;
    logic       en;
    logic       ampl;
    int         duty0;
    int         dinc;
    logic       drv_en;
    logic [1:0] mux;
    logic       busy;
    logic       done;
  } row_t;

  exp_t sb_q[$];
  row_t tbl[10];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   peak     = 0;

  function automatic exp_t mk(input logic de, input int d, input logic [1:0] m,
                              input logic b, input logic dn, input logic t);
    exp_t e;
    e.drv_en = de;
    e.duty   = d[6:0];
    e.mux    = m;
    e.busy   = b;
    e.done   = dn;
    e.tmo    = t;
    return e;
  endfunction

  // Expected outputs j edges after the FLAT entry edge of a burst.
  function automatic exp_t burst_exp(input int j, input logic [1:0] m, input logic t);
    int d;
    if (j < FLAT_T) begin
      return mk(1'b1, FLAT_D, m, 1'b1, 1'b0, t);
    end else if (j < FLAT_T + RAMP_T) begin
      d = FLAT_D + (j - FLAT_T);
      if (d > MAX_D) d = MAX_D;
      return mk(1'b1, d, m, 1'b1, 1'b0, t);
    end else begin
      return mk(1'b0, 0, M_OFF, 1'b0, 1'b1, 1'b0);
    end
  endfunction

  function automatic logic wd_zc(input int j);
    return ((j > 0) && (j <= WD_LAST_ZC) && (j % 5 == 0)) || (j == WD_NEXT_ZC) ||
           ((j >= WD_RACE_ZC) && (j <= 108) && ((j - WD_RACE_ZC) % 5 == 0));
  endfunction

  task automatic check_now(input string name, input int idx, input exp_t e);
    n_checks++;
    if (drv_en !== e.drv_en || duty !== e.duty || drv_mux !== e.mux ||
        busy !== e.busy || done !== e.done || zc_timeout !== e.tmo) begin
      n_fail++;
      $display("FAIL %s[%0d]: got drv_en=%b duty=%0d mux=%0d busy=%b done=%b tmo=%b, expected drv_en=%b duty=%0d mux=%0d busy=%b done=%b tmo=%b",
               name, idx, drv_en, duty, drv_mux, busy, done, zc_timeout,
               e.drv_en, e.duty, e.mux, e.busy, e.done, e.tmo);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic t_en, input logic t_fault, input logic t_zc,
                      input logic t_ampl, input exp_t e, input string name, input int idx);
    exp_t got_exp;
    en      = t_en;
    fault   = t_fault;
    zc      = t_zc;
    ampl_ok = t_ampl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (int'(duty) > peak) peak = int'(duty);
    got_exp = sb_q.pop_front();
    check_now(name, idx, got_exp);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    fault   = 1'b0;
    zc      = 1'b0;
    ampl_ok = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Start a burst from IDLE and drop en straight away; the burst must continue.
  task automatic pause_phase(input string name);
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), name, 0);
    for (int i = 1; i < PAUSE_T; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), name, i);
  endtask

  task automatic run_table();
    int d;
    int k;
    k = 0;
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < tbl[r].len; i++) begin
        d = tbl[r].duty0 + tbl[r].dinc * i;
        if (d > MAX_D) d = MAX_D;
        step(tbl[r].en, 1'b0, (k % 5 == 0), tbl[r].ampl,
             mk(tbl[r].drv_en, d, tbl[r].mux, tbl[r].busy, tbl[r].done, 1'b0),
             $sformatf("tbl%0d", r), i);
        k++;
      end
    end
  endtask

  task automatic run_watchdog();
    logic [1:0] m;
    logic       t;
    apply_reset();
    pause_phase("wd_pause");
    for (int j = 0; j <= FLAT_T + RAMP_T; j++) begin
      m = ((j >= WD_TMO) && (j < WD_NEXT_ZC)) ? M_INT : M_FB;
      t = (j == WD_TMO);
      step(1'b0, 1'b0, wd_zc(j), 1'b1, burst_exp(j, m, t), "wd", j);
    end
  endtask

  // last_j is the last normal record; fault is sampled at the following edge.
  task automatic run_fault(input int last_j);
    apply_reset();
    pause_phase("flt_pause");
    for (int j = 0; j <= last_j; j++)
      step(1'b0, 1'b0, (j > 0) && (j % 5 == 0), 1'b1, burst_exp(j, M_FB, 1'b0), "flt_run", j);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), "flt_abort", last_j + 1 + i);
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0), "flt_idle", last_j);
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), "flt_repause", 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), "flt_repause", 1);
  endtask

  task automatic run_async_reset();
    apply_reset();
    pause_phase("ar_pause");
    for (int j = 0; j <= 10; j++)
      step(1'b0, 1'b0, (j > 0) && (j % 5 == 0), 1'b1, burst_exp(j, M_FB, 1'b0), "ar_flat", j);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("ar_async", 0, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check_now("ar_held", 0, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0));
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0), "ar_idle", 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0), "ar_idle", 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(1'b0, 0, M_OFF, 1'b1, 1'b0, 1'b0), "ar_resume", 0);
  endtask

  initial begin
    // {len, en, ampl_ok, duty0, dinc, drv_en, mux, busy, done}
    tbl[0] = '{PAUSE_T,     1'b1, 1'b1, 0,      0, 1'b0, M_OFF, 1'b1, 1'b0};
    tbl[1] = '{FLAT_T,      1'b1, 1'b1, FLAT_D, 0, 1'b1, M_FB,  1'b1, 1'b0};
    tbl[2] = '{RAMP_T,      1'b1, 1'b1, FLAT_D, 1, 1'b1, M_FB,  1'b1, 1'b0};
    tbl[3] = '{1,           1'b1, 1'b1, 0,      0, 1'b0, M_OFF, 1'b0, 1'b1};
    tbl[4] = '{1,           1'b1, 1'b0, 0,      0, 1'b0, M_OFF, 1'b1, 1'b0};
    tbl[5] = '{PAUSE_T - 1, 1'b0, 1'b0, 0,      0, 1'b0, M_OFF, 1'b1, 1'b0};
    tbl[6] = '{FLAT_T,      1'b0, 1'b0, FLAT_D, 0, 1'b1, M_INT, 1'b1, 1'b0};
    tbl[7] = '{RAMP_T,      1'b0, 1'b0, FLAT_D, 1, 1'b1, M_INT, 1'b1, 1'b0};
    tbl[8] = '{1,           1'b0, 1'b0, 0,      0, 1'b0, M_OFF, 1'b0, 1'b1};
    tbl[9] = '{3,           1'b0, 1'b1, 0,      0, 1'b0, M_OFF, 1'b0, 1'b0};

    rst_n   = 1'b0;
    en      = 1'b0;
    fault   = 1'b0;
    zc      = 1'b0;
    ampl_ok = 1'b0;
    @(posedge clk);
    #1;
    check_now("reset_state", 0, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0));
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_now("post_reset_idle", 0, mk(1'b0, 0, M_OFF, 1'b0, 1'b0, 1'b0));

    run_table();
    n_checks++;
    if (peak != FLAT_D + RAMP_T - 1) begin
      n_fail++;
      $display("FAIL ramp_peak: got %0d, expected %0d", peak, FLAT_D + RAMP_T - 1);
    end

    run_watchdog();
    run_fault(FLAT_T + 40);
    run_fault(FLAT_T + RAMP_T - 1);
    run_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL time_budget: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "time budget exhausted");
  end

endmodule

// File: doc/qcw_ramp_seq.md
QCW_RAMP_SEQ -- requirements
Module: qcw_ramp_seq

Interface
REQ-001 SHALL have parameter REF_CLK_HZ, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter RAMP_PAUSE_MS, default 1, meaning the pause before each burst in ms.
REQ-003 SHALL have parameter FLAT_LENGTH_US, default 2000, meaning the flat-top (soft-start) duration in us.
REQ-004 SHALL have parameter RAMP_LENGTH_US, default 10000, meaning the ramp duration in us.
REQ-005 SHALL have parameter DUTY_SCALE, default 100, meaning the full-scale duty code.
REQ-006 SHALL have parameter FLAT_DUTY, default 10, meaning the duty code held during flat; must be less than MAX_DUTY.
REQ-007 SHALL have parameter MAX_DUTY, default 100, meaning the duty code at the end of the ramp; must not exceed DUTY_SCALE.
REQ-008 SHALL have parameter ZC_TIMEOUT_TICKS, default 2000, meaning the zero-cross watchdog limit in clk ticks.
REQ-009 SHALL have port clk, input, 1 bit: the single clock.
REQ-010 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-011 SHALL have port en, input, 1 bit: level; burst generation is permitted while high.
REQ-012 SHALL have port fault, input, 1 bit: level; forces an immediate abort.
REQ-013 SHALL have port zc, input, 1 bit: a one-cycle pulse on any zero-cross from the detector.
REQ-014 SHALL have port ampl_ok, input, 1 bit: feedback amplitude is adequate.
REQ-015 SHALL have port drv_mux, output, 2 bits: drive source select, off=0, internal=1, feedback=2.
REQ-016 SHALL have port duty, output, DUTY_BITS=$clog2(DUTY_SCALE+1) bits: the duty code for the driver.
REQ-017 SHALL have port drv_en, output, 1 bit: gate drive enable.
REQ-018 SHALL have ports busy (output, 1 bit), done (output, 1 bit, pulse) and zc_timeout (output, 1 bit, pulse).

Function
REQ-019 Derived tick constants SHALL be:
- PAUSE_TICKS = (REF_CLK_HZ/1000)*RAMP_PAUSE_MS
- FLAT_TICKS = (REF_CLK_HZ/1000000)*FLAT_LENGTH_US
- RAMP_TICKS = (REF_CLK_HZ/1000000)*RAMP_LENGTH_US
- STEP_TICKS = max(1, RAMP_TICKS/(MAX_DUTY-FLAT_DUTY))
REQ-020 FSM states SHALL be IDLE, PAUSE, FLAT, RAMP, ABORT; all outputs SHALL be registered.
REQ-021 IDLE SHALL produce drv_en=0, duty=0, drv_mux=off, busy=0; when en=1 and fault=0 it SHALL go to PAUSE on the next edge.
REQ-022 PAUSE SHALL last exactly PAUSE_TICKS cycles with drv_en=0 and busy=1, then go to FLAT.
REQ-023 FLAT SHALL last exactly FLAT_TICKS cycles with drv_en=1 and duty=FLAT_DUTY, then go to RAMP.
REQ-024 RAMP SHALL last exactly RAMP_TICKS cycles.
- duty starts at FLAT_DUTY and increments by 1 every STEP_TICKS cycles.
- duty saturates at MAX_DUTY and never wraps.
REQ-025 At the end of RAMP the block SHALL go to IDLE with drv_en=0, duty=0, and a one-cycle done=1.
REQ-026 If en is still high in IDLE, a new burst SHALL start, i.e. every burst is preceded by PAUSE.
REQ-027 en falling during PAUSE, FLAT or RAMP SHALL NOT stop the burst in progress.
REQ-028 drv_mux in FLAT/RAMP SHALL be feedback when ampl_ok=1 and the watchdog has not expired; otherwise internal.
REQ-029 The watchdog SHALL count cycles in FLAT/RAMP and clear to 0 on zc or on entry to FLAT.
REQ-030 When the watchdog reaches ZC_TIMEOUT_TICKS, the block SHALL:
- pulse zc_timeout for one cycle;
- force drv_mux=internal until the next zc;
- hold the counter saturated.
REQ-031 If zc and the timeout threshold occur in the same cycle, zc SHALL win: no timeout pulse, and the counter clears.
REQ-032 fault=1 in any state SHALL, on the next edge:
- enter ABORT;
- set drv_en=0, duty=0, drv_mux=off;
- keep busy=1;
- assert no done.
REQ-033 ABORT SHALL go to IDLE on the first cycle with fault=0.
REQ-034 fault has priority over all other transitions, including end of RAMP in the same cycle.

Reset
REQ-035 While rst_n=0, the block SHALL asynchronously hold:
- state IDLE and all counters 0;
- drv_en=0, duty=0, drv_mux=off;
- busy=0, done=0, zc_timeout=0.
REQ-036 Reset asserted mid-burst SHALL drop drv_en with no clock edge required; after rst_n rises, operation SHALL resume from IDLE.

Structure
REQ-037 The shared package (qcw_pkg) SHALL hold the drv_mux enum (off/internal/feedback) and the FSM state enum.
REQ-038 The package SHALL also hold the tick-conversion functions (ms/us to ticks).
REQ-039 The watchdog SHALL be one sub-module, zc_watchdog, with inputs clear/run and outputs expired/timeout pulse.

Verification (REF_CLK_HZ=1000000, RAMP_PAUSE_MS=1, FLAT_LENGTH_US=20, RAMP_LENGTH_US=90, FLAT_DUTY=10, MAX_DUTY=100, ZC_TIMEOUT_TICKS=8)
REQ-040 Nominal burst: en=1 held, zc every 5 cycles, ampl_ok=1 -> drv_en rises 1000 cycles after PAUSE entry; duty=10 for 20 cycles; duty=10..99 stepping once per cycle over 90 cycles; done pulse; drv_mux=feedback throughout.
REQ-041 Ramp saturation: STEP_TICKS=1 -> duty never exceeds 100 and never wraps to 0 before the RAMP exit.
REQ-042 Watchdog: zc stops mid-RAMP -> zc_timeout pulses 8 cycles after the last zc and drv_mux=internal; drv_mux returns to feedback the cycle after the next zc.
REQ-043 Watchdog race: zc coincides with tick 8 -> no zc_timeout pulse.
REQ-044 Fault: fault=1 at RAMP tick 40 -> next edge drv_en=0, duty=0, drv_mux=off, no done; fault=0 -> IDLE, then a new PAUSE if en=1.
REQ-045 Async reset: rst_n low mid-FLAT, between clock edges -> drv_en=0 immediately; after release, the block is in IDLE with all outputs 0.
